// File: rtl/sync_fifo_wl.sv
// Synchronous single-clock FIFO with water-level reporting.
// Standard mode: rd_data arrives 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after an
// accepted read, marked by a one-cycle rd_valid pulse; rd_data holds otherwise.
// FWFT mode: the head word sits on rd_data whenever empty=0, rd_en acknowledges it.
//
// Handshake: a write is taken on a clock edge where wr_en=1 and full=0; a read is
// taken on an edge where rd_en=1 and empty=0. Requests made while full/empty are
// dropped and latch the sticky overflow/underflow flags. rst wins over both.
module sync_fifo_wl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_REG    = 1,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic [ADDR_WIDTH:0]   almost_full_num,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   almost_empty_num,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage is never reset; the level counter alone decides what is valid.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  empty_q, empty_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    // Standard-mode read pipeline: stage 1 is only used when OUT_REG=1.
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    // Request qualification against the registered flags.
    always_comb begin
        wr_acc  = wr_en & ~full_q;
        rd_acc  = rd_en & ~empty_q;
        rd_word = mem_q[rd_ptr_q];
    end

    // Pointer, level and flag next-state; flags are derived from the post-edge level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
            2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
            default: level_d = level_q;
        endcase
        // level never exceeds DEPTH, so the MSB alone marks full.
        full_d         = level_d[ADDR_WIDTH];
        almost_full_d  = (level_d >= almost_full_num);
        empty_d        = (level_d == '0);
        almost_empty_d = (level_d <= almost_empty_num);
        overflow_d     = overflow_q | (wr_en & full_q);
        underflow_d    = underflow_q | (rd_en & empty_q);
    end

    // Standard-mode output path: one or two register stages after the accepted read.
    always_comb begin
        s1_valid_d  = rd_acc;
        s1_data_d   = s1_data_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        if (rd_acc) begin
            s1_data_d = rd_word;
        end
        if (OUT_REG != 0) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = s1_data_q;
            end
        end else begin
            out_valid_d = rd_acc;
            if (rd_acc) begin
                out_data_d = rd_word;
            end
        end
    end

    // Storage write; reset blocks a concurrent write.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // State registers; reset also flushes any read still in the output pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            s1_valid_q     <= s1_valid_d;
            s1_data_q      <= s1_data_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
        end
    end

    // Output mapping; in FWFT the head word is shown directly and forced to 0 when empty.
    always_comb begin
        full         = full_q;
        almost_full  = almost_full_q;
        empty        = empty_q;
        almost_empty = almost_empty_q;
        water_level  = level_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
        if (FWFT != 0) begin
            rd_data  = empty_q ? '0 : rd_word;
            rd_valid = ~empty_q;
        end else begin
            rd_data  = out_data_q;
            rd_valid = out_valid_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_wl.sv
// Bench for sync_fifo_wl: three instances (OUT_REG=0, OUT_REG=1, FWFT) share one
// stimulus stream and one reference model of the FIFO contents.
module tb_sync_fifo_wl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;
    logic [AW:0]   af_num;
    logic [AW:0]   ae_num;

    // index 0: OUT_REG=0, index 1: OUT_REG=1, index 2: FWFT
    logic [2:0]    full_v, afull_v, empty_v, aempty_v, rd_valid_v, ovf_v, unf_v;
    logic [DW-1:0] rd_data_v [3];
    logic [AW:0]   wl_v [3];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp0_q[$];
    int            stamp_q[$];
    int            stamp0_q[$];
    logic          mdl_ovf = 1'b0;
    logic          mdl_unf = 1'b0;
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;
    logic [AW:0]   af_seen = '0;
    logic [AW:0]   ae_seen = '0;
    logic          mon_en = 1'b0;

    sync_fifo_wl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .FWFT(0)) u_std0 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full_v[0]), .almost_full(afull_v[0]), .almost_full_num(af_num),
        .rd_data(rd_data_v[0]), .rd_en(rd_en), .rd_valid(rd_valid_v[0]),
        .empty(empty_v[0]), .almost_empty(aempty_v[0]), .almost_empty_num(ae_num),
        .water_level(wl_v[0]), .overflow(ovf_v[0]), .underflow(unf_v[0])
    );

    sync_fifo_wl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .FWFT(0)) u_std1 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full_v[1]), .almost_full(afull_v[1]), .almost_full_num(af_num),
        .rd_data(rd_data_v[1]), .rd_en(rd_en), .rd_valid(rd_valid_v[1]),
        .empty(empty_v[1]), .almost_empty(aempty_v[1]), .almost_empty_num(ae_num),
        .water_level(wl_v[1]), .overflow(ovf_v[1]), .underflow(unf_v[1])
    );

    sync_fifo_wl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full_v[2]), .almost_full(afull_v[2]), .almost_full_num(af_num),
        .rd_data(rd_data_v[2]), .rd_en(rd_en), .rd_valid(rd_valid_v[2]),
        .empty(empty_v[2]), .almost_empty(aempty_v[2]), .almost_empty_num(ae_num),
        .water_level(wl_v[2]), .overflow(ovf_v[2]), .underflow(unf_v[2])
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter and the thresholds as the DUT samples them.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        af_seen  <= af_num;
        ae_seen  <= ae_num;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic wr, input logic rd);
        rst = 1'b1; wr_en = wr; rd_en = rd; wr_data = 8'h5A;
        @(posedge clk);
        mdl_q.delete(); exp_q.delete(); exp0_q.delete();
        stamp_q.delete(); stamp0_q.delete();
        mdl_ovf = 1'b0; mdl_unf = 1'b0;
        last0 = '0; last1 = '0;
        mon_en = 1'b1;
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // One clock with the given requests; the model moves after the edge.
    task automatic cycle(input logic wr, input logic [DW-1:0] din, input logic rd);
        logic          wa, ra;
        logic [DW-1:0] d;
        int            st;
        wa = wr && (mdl_q.size() < DEPTH);
        ra = rd && (mdl_q.size() > 0);
        st = edge_cnt;
        wr_en = wr; wr_data = din; rd_en = rd;
        @(posedge clk);
        if (wr && !wa) mdl_ovf = 1'b1;
        if (rd && !ra) mdl_unf = 1'b1;
        if (ra) begin
            d = mdl_q.pop_front();
            exp_q.push_back(d);   stamp_q.push_back(st);
            exp0_q.push_back(d);  stamp0_q.push_back(st);
        end
        if (wa) mdl_q.push_back(din);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin : mon
        logic [DW-1:0] d;
        int            st;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (wl_v[k] !== (AW+1)'(mdl_q.size())) begin
                    n_fail++; $display("FAIL water_level[%0d]: got %0d expected %0d", k, wl_v[k], mdl_q.size());
                end
                n_checks++;
                if (full_v[k] !== (mdl_q.size() == DEPTH)) begin
                    n_fail++; $display("FAIL full[%0d]: got %b expected %b", k, full_v[k], mdl_q.size() == DEPTH);
                end
                n_checks++;
                if (afull_v[k] !== (mdl_q.size() >= int'(af_seen))) begin
                    n_fail++; $display("FAIL almost_full[%0d]: got %b expected %b (thr %0d)", k, afull_v[k], mdl_q.size() >= int'(af_seen), af_seen);
                end
                n_checks++;
                if (empty_v[k] !== (mdl_q.size() == 0)) begin
                    n_fail++; $display("FAIL empty[%0d]: got %b expected %b", k, empty_v[k], mdl_q.size() == 0);
                end
                n_checks++;
                if (aempty_v[k] !== (mdl_q.size() <= int'(ae_seen))) begin
                    n_fail++; $display("FAIL almost_empty[%0d]: got %b expected %b (thr %0d)", k, aempty_v[k], mdl_q.size() <= int'(ae_seen), ae_seen);
                end
                n_checks++;
                if (ovf_v[k] !== mdl_ovf) begin
                    n_fail++; $display("FAIL overflow[%0d]: got %b expected %b", k, ovf_v[k], mdl_ovf);
                end
                n_checks++;
                if (unf_v[k] !== mdl_unf) begin
                    n_fail++; $display("FAIL underflow[%0d]: got %b expected %b", k, unf_v[k], mdl_unf);
                end
            end
            // OUT_REG=0: word one cycle after its read, data held between pulses
            n_checks++;
            if (rd_valid_v[0] === 1'b1) begin
                if (exp0_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_valid_std0: got pulse expected none outstanding");
                end else begin
                    d = exp0_q.pop_front(); st = stamp0_q.pop_front();
                    if (rd_data_v[0] !== d) begin
                        n_fail++; $display("FAIL rd_data_std0: got %h expected %h", rd_data_v[0], d);
                    end
                    n_checks++;
                    if (edge_cnt != st + 1) begin
                        n_fail++; $display("FAIL latency_std0: got %0d expected %0d", edge_cnt - st, 1);
                    end
                    last0 = d;
                end
            end else if (rd_data_v[0] !== last0 || rd_valid_v[0] !== 1'b0) begin
                n_fail++; $display("FAIL hold_std0: got %h/%b expected %h/0", rd_data_v[0], rd_valid_v[0], last0);
            end
            // OUT_REG=1: word two cycles after its read
            n_checks++;
            if (rd_valid_v[1] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rd_valid_std1: got pulse expected none outstanding");
                end else begin
                    d = exp_q.pop_front(); st = stamp_q.pop_front();
                    if (rd_data_v[1] !== d) begin
                        n_fail++; $display("FAIL rd_data_std1: got %h expected %h", rd_data_v[1], d);
                    end
                    n_checks++;
                    if (edge_cnt != st + 2) begin
                        n_fail++; $display("FAIL latency_std1: got %0d expected %0d", edge_cnt - st, 2);
                    end
                    last1 = d;
                end
            end else if (rd_data_v[1] !== last1 || rd_valid_v[1] !== 1'b0) begin
                n_fail++; $display("FAIL hold_std1: got %h/%b expected %h/0", rd_data_v[1], rd_valid_v[1], last1);
            end
            // FWFT: head word visible whenever not empty
            n_checks++;
            if (rd_valid_v[2] !== (mdl_q.size() != 0)) begin
                n_fail++; $display("FAIL rd_valid_fwft: got %b expected %b", rd_valid_v[2], mdl_q.size() != 0);
            end
            if (mdl_q.size() != 0) begin
                n_checks++;
                if (rd_data_v[2] !== mdl_q[0]) begin
                    n_fail++; $display("FAIL rd_data_fwft: got %h expected %h", rd_data_v[2], mdl_q[0]);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        n_checks++;
        if (empty_v !== 3'b111 || aempty_v !== 3'b111 || full_v !== 3'b000 || afull_v !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got e%b ae%b f%b af%b expected e111 ae111 f000 af000", empty_v, aempty_v, full_v, afull_v);
        end
        n_checks++;
        if (rd_valid_v !== 3'b000 || ovf_v !== 3'b000 || unf_v !== 3'b000) begin
            n_fail++; $display("FAIL reset_sticky: got v%b o%b u%b expected 000 000 000", rd_valid_v, ovf_v, unf_v);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (wl_v[k] !== '0 || rd_data_v[k] !== '0) begin
                n_fail++; $display("FAIL reset_data[%0d]: got wl %0d data %h expected 0 00", k, wl_v[k], rd_data_v[k]);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            if (i == 12) begin
                n_checks++;
                if (afull_v !== 3'b000) begin n_fail++; $display("FAIL fill_afull_13: got %b expected 000", afull_v); end
            end
            if (i == 13) begin
                n_checks++;
                if (afull_v !== 3'b111) begin n_fail++; $display("FAIL fill_afull_14: got %b expected 111", afull_v); end
            end
            if (i == 14) begin
                n_checks++;
                if (full_v !== 3'b000) begin n_fail++; $display("FAIL fill_full_15: got %b expected 000", full_v); end
            end
        end
        n_checks++;
        if (full_v !== 3'b111 || wl_v[1] !== 5'd16) begin
            n_fail++; $display("FAIL fill_full_16: got %b wl %0d expected 111 wl 16", full_v, wl_v[1]);
        end
        cycle(1'b1, 8'hFF, 1'b0);
        n_checks++;
        if (ovf_v !== 3'b111 || wl_v[1] !== 5'd16) begin
            n_fail++; $display("FAIL fill_overflow: got %b wl %0d expected 111 wl 16", ovf_v, wl_v[1]);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (empty_v !== 3'b111) begin n_fail++; $display("FAIL drain_empty: got %b expected 111", empty_v); end
        n_checks++;
        if (unf_v !== 3'b000) begin n_fail++; $display("FAIL drain_no_underflow: got %b expected 000", unf_v); end
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (unf_v !== 3'b111) begin n_fail++; $display("FAIL drain_underflow: got %b expected 111", unf_v); end
        repeat (3) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            n_fail++; $display("FAIL drain_outstanding: got %0d/%0d expected 0/0", exp0_q.size(), exp_q.size());
        end
    endtask

    task automatic test_fwft();
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0);
        n_checks++;
        if (empty_v[2] !== 1'b0 || rd_data_v[2] !== 8'hA5) begin
            n_fail++; $display("FAIL fwft_first: got e%b %h expected e0 a5", empty_v[2], rd_data_v[2]);
        end
        cycle(1'b0, '0, 1'b1);
        n_checks++;
        if (empty_v[2] !== 1'b1) begin n_fail++; $display("FAIL fwft_ack: got e%b expected e1", empty_v[2]); end
        // back-to-back acknowledges with no bubble
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_empty_both();
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1);
        n_checks++;
        if (wl_v[1] !== 5'd1 || unf_v !== 3'b111 || ovf_v !== 3'b000) begin
            n_fail++; $display("FAIL empty_wr_rd: got wl %0d u%b o%b expected wl 1 u111 o000", wl_v[1], unf_v, ovf_v);
        end
        cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_concurrency();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        n_checks++;
        if (wl_v[0] !== 5'd15 || wl_v[1] !== 5'd15 || wl_v[2] !== 5'd15 || ovf_v !== 3'b111) begin
            n_fail++; $display("FAIL full_wr_rd: got wl %0d o%b expected wl 15 o111", wl_v[1], ovf_v);
        end
        for (int i = 0; i < 40; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b1);
        n_checks++;
        if (wl_v[1] !== 5'd15) begin n_fail++; $display("FAIL stream_level: got %0d expected 15", wl_v[1]); end
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_thresholds();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h70 + i), 1'b0);
        af_num = 5'd5;
        cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (afull_v !== 3'b111) begin n_fail++; $display("FAIL thr_af5: got %b expected 111", afull_v); end
        af_num = 5'd6; ae_num = 5'd5;
        cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (afull_v !== 3'b000 || aempty_v !== 3'b111) begin
            n_fail++; $display("FAIL thr_af6_ae5: got af%b ae%b expected af000 ae111", afull_v, aempty_v);
        end
        ae_num = 5'd4;
        cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (aempty_v !== 3'b000) begin n_fail++; $display("FAIL thr_ae4: got %b expected 000", aempty_v); end
        af_num = 5'd14; ae_num = 5'd2;
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (i % 25 == 0) begin
                af_num = (AW+1)'($urandom_range(1, DEPTH));
                ae_num = (AW+1)'($urandom_range(0, DEPTH - 1));
            end
            cycle($urandom_range(0, 99) < 55, DW'($urandom_range(0, 255)), $urandom_range(0, 99) < 45);
        end
        af_num = 5'd14; ae_num = 5'd2;
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
        n_checks++;
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            n_fail++; $display("FAIL random_outstanding: got %0d/%0d expected 0/0", exp0_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, DW'(8'h90 + i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        do_reset(1'b1, 1'b1);
        n_checks++;
        if (empty_v !== 3'b111 || aempty_v !== 3'b111 || full_v !== 3'b000 || afull_v !== 3'b000 ||
            rd_valid_v !== 3'b000 || ovf_v !== 3'b000 || unf_v !== 3'b000) begin
            n_fail++; $display("FAIL midreset_flags: got e%b ae%b f%b af%b v%b o%b u%b expected all reset values",
                               empty_v, aempty_v, full_v, afull_v, rd_valid_v, ovf_v, unf_v);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (wl_v[k] !== '0 || rd_data_v[k] !== '0) begin
                n_fail++; $display("FAIL midreset_data[%0d]: got wl %0d data %h expected 0 00", k, wl_v[k], rd_data_v[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0);
            n_checks++;
            if (rd_valid_v !== 3'b000) begin n_fail++; $display("FAIL midreset_pulse: got %b expected 000", rd_valid_v); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        af_num = 5'd14; ae_num = 5'd2;
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_empty_both();
        test_concurrency();
        test_thresholds();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
